// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: streams input/weight word pairs from the banked
// memory into the MAC datapath per output neuron and writes each activated result back.
module layer_sequencer #(
   parameter int RD_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  cfg_in_sector,
   input  logic [3:0]  cfg_w_base,
   input  logic [3:0]  cfg_out_sector,
   input  logic [4:0]  cfg_n_in,
   input  logic [4:0]  cfg_n_out,
   output logic [3:0]  read_add_1,
   output logic [3:0]  read_add_2,
   output logic [3:0]  read_sector_selector_1,
   output logic [3:0]  read_sector_selector_2,
   output logic        mac_en,
   output logic        mac_first,
   output logic        mac_last,
   input  logic        res_valid,
   input  logic [15:0] res_data,
   output logic        res_ready,
   output logic        write_enable,
   output logic [3:0]  sector_write_select,
   output logic [3:0]  write_address,
   output logic [15:0] data_write,
   output logic        busy,
   output logic        done
);
   // state    | meaning
   // IDLE     | waiting for start, config not latched
   // READ     | issuing operand address pair k of neuron o
   // DRAIN    | read pipeline emptying, last addresses held
   // WAIT_RES | res_ready high, waiting for the activation result
   // WRITE    | writing the result of neuron o to the output sector
   // DONE     | one-cycle done pulse
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] READ     = 3'd1;
   localparam logic [2:0] DRAIN    = 3'd2;
   localparam logic [2:0] WAIT_RES = 3'd3;
   localparam logic [2:0] WRITE    = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;
   localparam int DCW = $clog2(RD_LAT + 1);

   logic [2:0]        state;
   logic [3:0]        in_sector, w_base, out_sector;
   logic [4:0]        n_in, n_out, o, k;
   logic [DCW-1:0]    drain_cnt;
   logic [3:0]        rd_addr, rd_sec1, rd_sec2;
   logic [15:0]       res_q;
   logic [RD_LAT-1:0] v_pipe, f_pipe, l_pipe;
   logic              issue, k_last;

   function automatic logic [4:0] sat16(input logic [4:0] v);
      return (v > 5'd16) ? 5'd16 : v;
   endfunction

   assign issue  = (state == READ);
   assign k_last = (k == n_in - 5'd1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         in_sector  <= '0;
         w_base     <= '0;
         out_sector <= '0;
         n_in       <= '0;
         n_out      <= '0;
         o          <= '0;
         k          <= '0;
         drain_cnt  <= '0;
         rd_addr    <= '0;
         rd_sec1    <= '0;
         rd_sec2    <= '0;
         res_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  in_sector  <= cfg_in_sector;
                  w_base     <= cfg_w_base;
                  out_sector <= cfg_out_sector;
                  n_in       <= sat16(cfg_n_in);
                  n_out      <= sat16(cfg_n_out);
                  o          <= '0;
                  k          <= '0;
                  if (cfg_n_in == 5'd0 || cfg_n_out == 5'd0) begin
                     state <= DONE;
                  end else begin
                     state   <= READ;
                     rd_addr <= '0;
                     rd_sec1 <= cfg_in_sector;
                     rd_sec2 <= cfg_w_base;
                  end
               end
            end
            READ: begin
               if (k_last) begin
                  k         <= '0;
                  drain_cnt <= DCW'(RD_LAT - 1);
                  state     <= DRAIN;
               end else begin
                  k       <= k + 5'd1;
                  rd_addr <= k[3:0] + 4'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state <= WAIT_RES;
               else                 drain_cnt <= drain_cnt - 1'b1;
            end
            WAIT_RES: begin
               if (res_valid) begin
                  res_q <= res_data;
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (o == n_out - 5'd1) begin
                  state <= DONE;
               end else begin
                  // weight sector of the next neuron wraps modulo 16
                  o       <= o + 5'd1;
                  k       <= '0;
                  rd_addr <= '0;
                  rd_sec2 <= w_base + o[3:0] + 4'd1;
                  state   <= READ;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Issue tags travel alongside the memory read so they line up with read data.
   always_ff @(posedge clock) begin
      if (reset) begin
         v_pipe <= '0;
         f_pipe <= '0;
         l_pipe <= '0;
      end else begin
         v_pipe[0] <= issue;
         f_pipe[0] <= issue && (k == 5'd0);
         l_pipe[0] <= issue && k_last;
         for (int i = 1; i < RD_LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            f_pipe[i] <= f_pipe[i-1];
            l_pipe[i] <= l_pipe[i-1];
         end
      end
   end

   assign read_add_1             = rd_addr;
   assign read_add_2             = rd_addr;
   assign read_sector_selector_1 = rd_sec1;
   assign read_sector_selector_2 = rd_sec2;
   assign mac_en                 = v_pipe[RD_LAT-1];
   assign mac_first              = f_pipe[RD_LAT-1];
   assign mac_last               = l_pipe[RD_LAT-1];
   assign res_ready              = (state == WAIT_RES);
   assign write_enable           = (state == WRITE);
   assign sector_write_select    = (state == WRITE) ? out_sector : 4'd0;
   assign write_address          = (state == WRITE) ? o[3:0] : 4'd0;
   assign data_write             = (state == WRITE) ? res_q : 16'd0;
   assign busy                   = (state != IDLE);
   assign done                   = (state == DONE);
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Controller that sequences one fully-connected layer pass through the 16-sector banked memory: 16 sectors × 16 words × 16 bits, one write port and two read ports. For each output neuron it streams input-vector words on read port 1 and the matching weight-row words on read port 2 into the MAC datapath. It then waits for the activated result and writes it back to an output sector. It sits between the top-level control FSM, which issues start/config, and the memory plus MAC/activation datapath.

## Interface
Parameters:
- RD_LAT, 1: memory read latency in clocks, from address/sector change to valid read data (≥1).

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_in_sector  in  4  sector holding the input vector (word k = input k)
- cfg_w_base  in  4  sector holding weight row of neuron 0; neuron o uses sector (cfg_w_base+o) mod 16
- cfg_out_sector  in  4  sector receiving results (word o = neuron o)
- cfg_n_in  in  5  inputs per neuron, 0..16
- cfg_n_out  in  5  neurons, 0..16
- read_add_1, read_add_2  out  4  read word addresses, ports 1/2
- read_sector_selector_1, read_sector_selector_2  out  4  read sector selects, ports 1/2
- mac_en  out  1  read_data_1/read_data_2 currently valid as an operand pair
- mac_first  out  1  with mac_en: first pair of a neuron (MAC clears accumulator)
- mac_last  out  1  with mac_en: last pair of a neuron
- res_valid  in  1  activation result valid
- res_data  in  16  activation result
- res_ready  out  1  high in WAIT_RES; a result transfers when res_valid && res_ready
- write_enable  out  1  memory write strobe
- sector_write_select  out  4  write sector
- write_address  out  4  write word address
- data_write  out  16  write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass

## Operation
- Config is latched on start in IDLE. start outside IDLE is ignored. Latched config is stable for the whole pass.
- n_in or n_out equal to 0: IDLE → DONE directly. No reads, no writes, no mac_en. Values >16 are saturated to 16.
- States: IDLE, READ, DRAIN, WAIT_RES, WRITE, DONE. Neuron counter o (5b) and input counter k (5b) reset to 0 on start.
- READ: each cycle drives read_add_1=read_add_2=k[3:0], read_sector_selector_1=in_sector, read_sector_selector_2=(w_base+o)[3:0] (4-bit wrap), then k++.
  - The issue tags valid/first(k==0)/last(k==n_in−1) enter an RD_LAT-deep shift pipeline.
  - After issuing k=n_in−1: → DRAIN, k←0.
- DRAIN: holds the last addresses for RD_LAT cycles while the pipeline empties, then → WAIT_RES.
- mac_en/mac_first/mac_last are the pipeline outputs, RD_LAT cycles after the corresponding issue. Exactly n_in mac_en pulses per neuron, contiguous.
- WAIT_RES: res_ready=1. On res_valid, latch res_data → WRITE. res_valid in any other state is ignored and not stored.
- WRITE (1 cycle): write_enable=1, sector_write_select=out_sector, write_address=o[3:0], data_write=latched result.
  - If o==n_out−1 → DONE, otherwise o++ and → READ.
- DONE (1 cycle): done=1, then → IDLE.
- out_sector equal to in_sector or to a weight sector is legal. The write of neuron o lands after all reads of neuron o, so later neurons see updated data; this is intended, not guarded.
- Reset at any cycle: return to IDLE, flush the pipeline, abort the pass, write nothing further.

## Timing
- Reset values: all outputs 0, including addresses, selectors, data_write and the mac_* flags. State is IDLE.
- start at cycle 0 → first READ issue at cycle 1; busy=1 from cycle 1.
- Per neuron: n_in READ + RD_LAT DRAIN + ≥1 WAIT_RES + 1 WRITE cycles.
- With res_valid already high on WAIT_RES entry, neuron period = n_in+RD_LAT+2.
- First mac_en at cycle 1+RD_LAT.
- done asserts the cycle after the last WRITE. busy drops the cycle after done.
- write_enable is never high outside WRITE. mac_en is never high in WAIT_RES/WRITE/DONE/IDLE.

## Test plan
- RD_LAT=1, in=2, w_base=4, out=9, n_in=3, n_out=2, res_valid tied high, res_data=0x00A0+o → reads (sector 2 / sectors 4,5, addresses 0,1,2); mac_first/last on pairs 1/3 of each neuron; writes 0x00A0 to 9/0 then 0x00A1 to 9/1; done at cycle 13.
- n_in=16, n_out=16, w_base=3 → weight sector wraps 15→0→1 for neurons 12..15; 256 mac_en pulses; 16 writes to addresses 0..15.
- res_valid delayed 5 cycles in WAIT_RES, plus res_valid pulses injected during READ → the stall holds all outputs; the injected pulses are ignored; no extra writes.
- cfg_n_in=0 (and separately cfg_n_out=0) → done on the cycle after start, zero mac_en, zero write_enable.
- Reset asserted mid-READ of neuron 1 → next cycle IDLE, all outputs 0; mac_en does not assert again and no write occurs; a new start then runs cleanly.
- start pulsed while busy with different config → ignored; the pass completes with the original config. Repeat the first scenario with RD_LAT=2 → mac_en shifted one cycle; done at cycle 15.
